aes256_key_sched_ctrl: RTL and testbench
========================================

Name: aes256_key_sched_ctrl

Overview:
- Sequencer for the combinational AES-256 key-expansion datapath. That datapath takes a 4-bit round constant index and a 256-bit key state, and returns the next 256-bit state (two round keys).
- Accepts a cipher key through a valid/ready handshake and drives the expansion datapath for 7 iterations, one per clock.
- Stores all 15 round keys (128 bits each) in a local register file.
- Serves round keys to the cipher round engine through a registered read port.

Parameters:
- NUM_RK, 15, number of 128-bit round keys stored. Fixed for AES-256; any other value is unsupported.
- CLR_ON_LOAD, 1, when 1 a key load zeroes round keys 2..14 before expansion refills them.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_valid  input  1  cipher key present on key_in.
- key_ready  output  1  controller can accept a key.
- key_in  input  256  cipher key; bits [255:224] are word w0.
- exp_rc  output  4  round-constant index to the expansion datapath.
- exp_key  output  256  current key state to the expansion datapath.
- exp_next  input  256  expanded state returned by the datapath (combinational from exp_key/exp_rc).
- busy  output  1  expansion in progress.
- keys_valid  output  1  all 15 round keys are valid.
- done  output  1  one-cycle pulse when expansion completes.
- rd_en  input  1  round-key read request.
- rd_idx  input  4  round-key index, 0..14.
- rd_data  output  128  round key, registered.
- rd_vld  output  1  rd_data valid; high one cycle after rd_en.

Behaviour:
- Reset (async assert, sync deassert via rst_n):
  - State IDLE.
  - key_ready=1; busy=0; keys_valid=0; done=0; rd_vld=0.
  - rd_data=0; exp_rc=0; exp_key=0.
  - All stored round keys = 0; iteration counter = 0.
- FSM states: IDLE, EXPAND, READY.
- key_ready is 1 in IDLE and READY, 0 in EXPAND.
- Accept: on a clk edge with key_valid & key_ready:
  - rk[0] <= key_in[255:128]; rk[1] <= key_in[127:0].
  - State register <= key_in; iteration counter <= 1; state <= EXPAND.
  - keys_valid <= 0; busy <= 1.
  - If CLR_ON_LOAD=1, rk[2..14] <= 0.
- In EXPAND, exp_key = state register and exp_rc = iteration counter, both driven directly from registers (not from the FSM decode).
- EXPAND iteration i (1..7), each clock edge:
  - State register <= exp_next.
  - rk[2i] <= exp_next[255:128].
  - If i<7, rk[2i+1] <= exp_next[127:0]. At i=7 the lower half is discarded (rk15 does not exist).
  - Counter <= i+1.
- After the i=7 edge:
  - state <= READY; busy <= 0; keys_valid <= 1; done <= 1 for exactly one cycle.
  - exp_rc and exp_key hold their last values.
- Latency: the accept edge is T; keys_valid rises at edge T+7; exactly 7 EXPAND cycles.
- Back-to-back load: in READY a new key_valid is accepted the same way as in IDLE, and keys_valid drops on the accept edge. key_valid during EXPAND is ignored (key_ready=0); no abort and no queueing.
- Read port:
  - On an edge with rd_en=1, rd_vld <= 1 and rd_data <= rk[rd_idx]. If rd_idx>14, rd_data <= 0.
  - With rd_en=0, rd_vld <= 0 and rd_data holds its value.
  - Reads are legal in any state and return the current register contents. Reads during EXPAND may return partial keys; consumers gate on keys_valid.
- Simultaneous read and write of the same index on one edge: the read returns the pre-edge (old) value.
- Reset asserted mid-EXPAND: everything returns immediately to reset values, including all round keys.
- rc encoding: exp_rc runs 1..7 in order. Values 0 and 8..15 are never driven while busy=1.

Test Plan:
- Reset: hold rst_n=0, drive key_valid=1 -> key_ready=1, busy=0, keys_valid=0, rd_data=0. No accept occurs while in reset.
- FIPS-197 AES-256 key 000102..1f: pulse key_valid at T -> exp_rc sequence 1,2,..,7 at T+1..T+7. keys_valid and done rise at T+7, with done high for 1 cycle. Reads then give rk0=000102030405060708090a0b0c0d0e0f, rk1=101112131415161718191a1b1c1d1e1f, rk14=24fc79ccbf0979e9371ac23c6d68de36.
- Load during EXPAND: assert key_valid with a second key at T+3 -> ignored, rk14 still 24fc79cc...; then reload in READY -> keys_valid drops on the accept edge and rises 7 cycles later with the new set.
- Read boundaries: rd_idx=14 returns rk14; rd_idx=15 returns 0 with rd_vld=1. rd_en=0 gives rd_vld=0 next cycle and rd_data held.
- Reset mid-expansion: drop rst_n at T+4 -> busy=0, keys_valid=0 immediately; read of rk0 after reset returns 0.
- CLR_ON_LOAD=1: load key A, then key B, and read rk10 at T+2 -> 0, not key A's rk10.

Source files
------------

// File: rtl/aes256_key_sched_ctrl.sv
// AES-256 key-schedule sequencer: accepts a cipher key, walks the external expansion
// datapath through 7 steps and serves the 15 resulting round keys over a registered read port.
module aes256_key_sched_ctrl #(
    parameter int unsigned NUM_RK      = 15,
    parameter bit          CLR_ON_LOAD = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         key_valid_i,
    output logic         key_ready_o,
    input  logic [255:0] key_in_i,
    output logic [3:0]   exp_rc_o,
    output logic [255:0] exp_key_o,
    input  logic [255:0] exp_next_i,
    output logic         busy_o,
    output logic         keys_valid_o,
    output logic         done_o,
    input  logic         rd_en_i,
    input  logic [3:0]   rd_idx_i,
    output logic [127:0] rd_data_o,
    output logic         rd_vld_o
);

    typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

    localparam logic [3:0] LastIter = 4'd7;

    state_e         state_q, state_d;
    logic [255:0]   key_state_q, key_state_d;
    logic [3:0]     iter_q, iter_d;
    logic [127:0]   rk_q [NUM_RK];
    logic [127:0]   rk_d [NUM_RK];
    logic           done_q, done_d;
    logic [127:0]   rd_data_q, rd_data_d;
    logic           rd_vld_q, rd_vld_d;

    logic accept;
    logic last_iter;

    assign accept    = key_valid_i & key_ready_o;
    assign last_iter = (iter_q == LastIter);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StReady: begin
                if (key_valid_i) begin
                    state_d = StExpand;
                end
            end
            StExpand: begin
                if (last_iter) begin
                    state_d = StReady;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        key_ready_o  = 1'b0;
        busy_o       = 1'b0;
        keys_valid_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                key_ready_o = 1'b1;
            end
            StExpand: begin
                busy_o = 1'b1;
            end
            StReady: begin
                key_ready_o  = 1'b1;
                keys_valid_o = 1'b1;
            end
            default: begin
                key_ready_o = 1'b0;
            end
        endcase
    end

    // Key state, iteration counter and round-key file updates
    always_comb begin
        key_state_d = key_state_q;
        iter_d      = iter_q;
        rk_d        = rk_q;
        done_d      = 1'b0;

        if (accept) begin
            key_state_d = key_in_i;
            iter_d      = 4'd1;
            rk_d[0]     = key_in_i[255:128];
            rk_d[1]     = key_in_i[127:0];
            if (CLR_ON_LOAD) begin
                for (int unsigned j = 2; j < NUM_RK; j++) begin
                    rk_d[j] = '0;
                end
            end
        end else if (busy_o) begin
            // The final step only yields rk14; its lower half has no slot and
            // the exposed key state / rc hold their last values.
            for (int unsigned j = 2; j < NUM_RK; j++) begin
                if (j == 2 * 32'(iter_q)) begin
                    rk_d[j] = exp_next_i[255:128];
                end else if (!last_iter && (j == 2 * 32'(iter_q) + 1)) begin
                    rk_d[j] = exp_next_i[127:0];
                end
            end
            if (last_iter) begin
                done_d = 1'b1;
            end else begin
                key_state_d = exp_next_i;
                iter_d      = iter_q + 4'd1;
            end
        end
    end

    // Read port: out-of-range indices return zero
    always_comb begin
        rd_vld_d  = rd_en_i;
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = '0;
            for (int unsigned j = 0; j < NUM_RK; j++) begin
                if (32'(rd_idx_i) == j) begin
                    rd_data_d = rk_q[j];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_state_q <= '0;
            iter_q      <= '0;
            done_q      <= 1'b0;
            rd_data_q   <= '0;
            rd_vld_q    <= 1'b0;
            for (int unsigned j = 0; j < NUM_RK; j++) begin
                rk_q[j] <= '0;
            end
        end else begin
            key_state_q <= key_state_d;
            iter_q      <= iter_d;
            done_q      <= done_d;
            rd_data_q   <= rd_data_d;
            rd_vld_q    <= rd_vld_d;
            rk_q        <= rk_d;
        end
    end

    assign exp_key_o = key_state_q;
    assign exp_rc_o  = iter_q;
    assign done_o    = done_q;
    assign rd_data_o = rd_data_q;
    assign rd_vld_o  = rd_vld_q;

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// Directed bench for aes256_key_sched_ctrl; supplies a behavioural AES-256 expansion step
// as the datapath and checks sequencing, storage and the read port.
module tb_aes256_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_valid;
    logic         key_ready;
    logic [255:0] key_in;
    logic [3:0]   exp_rc;
    logic [255:0] exp_key;
    logic [255:0] exp_next;
    logic         busy;
    logic         keys_valid;
    logic         done;
    logic         rd_en;
    logic [3:0]   rd_idx;
    logic [127:0] rd_data;
    logic         rd_vld;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [255:0] KEY_A =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_B =
        256'hfedcba98765432100f1e2d3c4b5a69788899aabbccddeeff13579bdf2468ace0;
    localparam logic [127:0] A_RK0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] A_RK1  = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] A_RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // One AES-256 expansion step: 8 words in, next 8 words out.
    function automatic logic [255:0] key_step(input logic [255:0] s, input logic [3:0] rc);
        logic [31:0] w [8];
        logic [31:0] n [8];
        logic [7:0]  rcon;
        logic [255:0] r;
        for (int k = 0; k < 8; k++) w[k] = s[255 - 32*k -: 32];
        rcon = (rc >= 4'd1 && rc <= 4'd8) ? 8'(1 << (rc - 4'd1)) : 8'h00;
        n[0] = w[0] ^ sub_word({w[7][23:0], w[7][31:24]}) ^ {rcon, 24'h0};
        for (int k = 1; k < 4; k++) n[k] = w[k] ^ n[k-1];
        n[4] = w[4] ^ sub_word(n[3]);
        for (int k = 5; k < 8; k++) n[k] = w[k] ^ n[k-1];
        for (int k = 0; k < 8; k++) r[255 - 32*k -: 32] = n[k];
        return r;
    endfunction

    function automatic logic [127:0] model_rk(input logic [255:0] key, input int idx);
        logic [255:0] s;
        s = key;
        if (idx == 0) return key[255:128];
        if (idx == 1) return key[127:0];
        for (int i = 1; i <= 7; i++) begin
            s = key_step(s, 4'(i));
            if (idx == 2*i)     return s[255:128];
            if (idx == 2*i + 1) return s[127:0];
        end
        return '0;
    endfunction

    always_comb exp_next = key_step(exp_key, exp_rc);

    aes256_key_sched_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .key_valid_i (key_valid),
        .key_ready_o (key_ready),
        .key_in_i    (key_in),
        .exp_rc_o    (exp_rc),
        .exp_key_o   (exp_key),
        .exp_next_i  (exp_next),
        .busy_o      (busy),
        .keys_valid_o(keys_valid),
        .done_o      (done),
        .rd_en_i     (rd_en),
        .rd_idx_i    (rd_idx),
        .rd_data_o   (rd_data),
        .rd_vld_o    (rd_vld)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [255:0] key);
        key_valid = 1'b1;
        key_in    = key;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic read_rk(input logic [3:0] idx, input logic [127:0] exp, input string tag);
        rd_en  = 1'b1;
        rd_idx = idx;
        tick();
        rd_en  = 1'b0;
        check_eq({tag, "_vld"}, 256'(rd_vld), 256'(1));
        check_eq(tag, 256'(rd_data), 256'(exp));
    endtask

    task automatic wait_keys(input int exp_cycles, input string tag);
        int cycles;
        cycles = 0;
        while (!keys_valid && cycles < 20) begin
            tick();
            cycles++;
        end
        check_eq(tag, 256'(cycles), 256'(exp_cycles));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b1;
        key_valid = 1'b0;
        key_in    = '0;
        rd_en     = 1'b0;
        rd_idx    = '0;
        #2 rst_n  = 1'b0;

        // Reset with a key offered: nothing is accepted
        key_valid = 1'b1;
        key_in    = KEY_A;
        tick();
        tick();
        check_eq("rst_key_ready", 256'(key_ready), 256'(1));
        check_eq("rst_busy", 256'(busy), 256'(0));
        check_eq("rst_keys_valid", 256'(keys_valid), 256'(0));
        check_eq("rst_done", 256'(done), 256'(0));
        check_eq("rst_rd_vld", 256'(rd_vld), 256'(0));
        check_eq("rst_rd_data", 256'(rd_data), 256'(0));
        check_eq("rst_exp_rc", 256'(exp_rc), 256'(0));
        check_eq("rst_exp_key", exp_key, 256'(0));
        key_valid = 1'b0;
        rst_n     = 1'b1;
        tick();
        check_eq("idle_busy", 256'(busy), 256'(0));

        // FIPS-197 key: rc sequence, latency and done pulse
        load_key(KEY_A);
        check_eq("acc_key_ready", 256'(key_ready), 256'(0));
        check_eq("acc_exp_key", exp_key, KEY_A);
        for (int i = 1; i <= 7; i++) begin
            check_eq($sformatf("exp_rc_%0d", i), 256'(exp_rc), 256'(i));
            check_eq($sformatf("busy_%0d", i), 256'(busy), 256'(1));
            check_eq($sformatf("kv_low_%0d", i), 256'(keys_valid), 256'(0));
            tick();
        end
        check_eq("fin_keys_valid", 256'(keys_valid), 256'(1));
        check_eq("fin_done", 256'(done), 256'(1));
        check_eq("fin_busy", 256'(busy), 256'(0));
        check_eq("fin_exp_rc_hold", 256'(exp_rc), 256'(7));
        tick();
        check_eq("done_pulse_end", 256'(done), 256'(0));
        check_eq("kv_held", 256'(keys_valid), 256'(1));

        read_rk(4'd0, A_RK0, "a_rk0");
        read_rk(4'd1, A_RK1, "a_rk1");
        read_rk(4'd7, model_rk(KEY_A, 7), "a_rk7");
        read_rk(4'd15, 128'h0, "rd_idx15");
        read_rk(4'd14, A_RK14, "a_rk14");
        tick();
        check_eq("rd_idle_vld", 256'(rd_vld), 256'(0));
        check_eq("rd_idle_hold", 256'(rd_data), 256'(A_RK14));

        // Reload from READY; a key offered mid-expansion is ignored
        load_key(KEY_A);
        check_eq("reload_kv_drop", 256'(keys_valid), 256'(0));
        tick();
        tick();
        key_valid = 1'b1;
        key_in    = KEY_B;
        check_eq("exp_key_ready", 256'(key_ready), 256'(0));
        tick();
        key_valid = 1'b0;
        wait_keys(4, "mid_load_latency");
        read_rk(4'd14, A_RK14, "ignored_rk14");

        load_key(KEY_B);
        check_eq("b_kv_drop", 256'(keys_valid), 256'(0));
        wait_keys(7, "b_latency");
        read_rk(4'd0, KEY_B[255:128], "b_rk0");
        read_rk(4'd1, KEY_B[127:0], "b_rk1");
        read_rk(4'd10, model_rk(KEY_B, 10), "b_rk10");
        read_rk(4'd14, model_rk(KEY_B, 14), "b_rk14");

        // Clear-on-load: rk10 of the previous key is gone by T+2
        load_key(KEY_A);
        tick();
        read_rk(4'd10, 128'h0, "clr_rk10");
        wait_keys(5, "clr_latency");
        read_rk(4'd10, model_rk(KEY_A, 10), "a_rk10");

        // Reset mid-expansion
        load_key(KEY_B);
        tick();
        tick();
        tick();
        tick();
        check_eq("pre_rst_busy", 256'(busy), 256'(1));
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", 256'(busy), 256'(0));
        check_eq("mid_rst_kv", 256'(keys_valid), 256'(0));
        check_eq("mid_rst_ready", 256'(key_ready), 256'(1));
        check_eq("mid_rst_rc", 256'(exp_rc), 256'(0));
        check_eq("mid_rst_rd_data", 256'(rd_data), 256'(0));
        tick();
        rst_n = 1'b1;
        tick();
        read_rk(4'd0, 128'h0, "post_rst_rk0");
        read_rk(4'd14, 128'h0, "post_rst_rk14");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
